// File: rtl/cordic_dot_accumulator.sv
// Drives an iterative 8x8 multiplier one operand pair at a time over a level-held
// start/done protocol and accumulates the signed products into a saturating dot product.
module cordic_dot_accumulator #(
    parameter int ACC_W   = 24,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_x,
    input  logic [7:0]        in_z,
    input  logic              in_last,
    output logic              mul_start,
    output logic [7:0]        mul_x,
    output logic [7:0]        mul_z,
    input  logic [15:0]       mul_y,
    input  logic              mul_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic              out_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RELEASE,
        S_OUT
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state_q, state_d;
    logic [7:0]       mul_x_q, mul_x_d;
    logic [7:0]       mul_z_q, mul_z_d;
    logic             last_q, last_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;
    logic [ACC_W:0]   sum;

    // One guard bit: overflow shows up as disagreement between the top two sum bits.
    assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-16){mul_y[15]}}, mul_y};

    always_comb begin
        state_d = state_q;
        mul_x_d = mul_x_q;
        mul_z_d = mul_z_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        acc_d   = acc_q;
        count_d = count_q;
        sat_d   = sat_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mul_x_d = in_x;
                    mul_z_d = in_z;
                    last_d  = in_last;
                    tmo_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (mul_done) begin
                    if (sum[ACC_W] != sum[ACC_W-1]) begin
                        acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    count_d = count_q + CNT_W'(1);
                    state_d = S_RELEASE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // Abandon the multiply: the pair is counted but contributes nothing.
                    err_d   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    state_d = S_RELEASE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RELEASE: begin
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mul_x_q <= '0;
            mul_z_q <= '0;
            last_q  <= 1'b0;
            tmo_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mul_x_q <= mul_x_d;
            mul_z_q <= mul_z_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    // mul_start is decoded straight from the state so reset drops it (and the multiplier) at once.
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign mul_start = (state_q == S_RUN);
    assign out_valid = (state_q == S_OUT);
    assign mul_x     = mul_x_q;
    assign mul_z     = mul_z_q;
    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_sat   = sat_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_cordic_dot_accumulator.sv
// Directed bench: two accumulator widths (24 and 16) driven in lockstep against
// 16-iteration multiplier stubs returning programmed products.
module tb_cordic_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_x = '0;
    logic [7:0]  in_z = '0;
    logic [15:0] stub_y = '0;
    logic        hang = 1'b0;

    logic        in_ready_a, mul_start_a, mul_done_a, out_valid_a, out_sat_a, out_err_a;
    logic [7:0]  mul_x_a, mul_z_a, out_count_a;
    logic [23:0] out_acc_a;
    logic        in_ready_b, mul_start_b, mul_done_b, out_valid_b, out_sat_b, out_err_b;
    logic [7:0]  mul_x_b, mul_z_b, out_count_b;
    logic [15:0] out_acc_b;
    logic [4:0]  it_a = '0;
    logic [4:0]  it_b = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cordic_dot_accumulator #(.ACC_W(24), .TIMEOUT(32), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_x(in_x), .in_z(in_z), .in_last(in_last), .mul_start(mul_start_a),
        .mul_x(mul_x_a), .mul_z(mul_z_a), .mul_y(stub_y), .mul_done(mul_done_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
        .out_count(out_count_a), .out_sat(out_sat_a), .out_err(out_err_a)
    );

    cordic_dot_accumulator #(.ACC_W(16), .TIMEOUT(32), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_x(in_x), .in_z(in_z), .in_last(in_last), .mul_start(mul_start_b),
        .mul_x(mul_x_b), .mul_z(mul_z_b), .mul_y(stub_y), .mul_done(mul_done_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
        .out_count(out_count_b), .out_sat(out_sat_b), .out_err(out_err_b)
    );

    // Multiplier stubs: iteration counter held at zero while start is low, done at 16.
    always @(posedge clk) begin
        it_a <= !mul_start_a ? 5'd0 : (it_a < 5'd16 ? it_a + 5'd1 : it_a);
        it_b <= !mul_start_b ? 5'd0 : (it_b < 5'd16 ? it_b + 5'd1 : it_b);
    end
    assign mul_done_a = !hang && (it_a == 5'd16);
    assign mul_done_b = !hang && (it_b == 5'd16);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one pair, waits out RUN and RELEASE; returns with the DUT in IDLE or OUT.
    task automatic send_pair(input logic [7:0] x, input logic [7:0] z, input logic last,
                             input logic [15:0] y, output int run_cycles);
        int t;
        stub_y   = y;
        in_x     = x;
        in_z     = z;
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready_a && t < 50) begin
            tick();
            t++;
        end
        check_val("accept_ready", in_ready_a, 1'b1);
        tick();
        in_valid = 1'b0;
        check_val("mul_x_held", mul_x_a, x);
        check_val("mul_z_held", mul_z_a, z);
        run_cycles = 0;
        while (mul_start_a && run_cycles < 100) begin
            run_cycles++;
            tick();
        end
        check_val("rel_ready", in_ready_a, 1'b0);
        check_val("rel_valid", out_valid_a, 1'b0);
        tick();
        check_val("post_ready", in_ready_a, !last);
        check_val("post_valid", out_valid_a, last);
        $display("pair x=%0d z=%0d y=%0h last=%0b run=%0d acc24=%0h acc16=%0h",
                 $signed(x), $signed(z), y, last, run_cycles, out_acc_a, out_acc_b);
    endtask

    task automatic drain();
        check_val("drain_valid", out_valid_a, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("drained_valid", out_valid_a, 1'b0);
        check_val("drained_ready", in_ready_a, 1'b1);
    endtask

    initial begin
        int rc;

        // Reset state
        tick();
        check_val("rst_in_ready", in_ready_a, 1'b0);
        check_val("rst_mul_start", mul_start_a, 1'b0);
        check_val("rst_out_valid", out_valid_a, 1'b0);
        check_val("rst_mul_x", mul_x_a, 8'h00);
        rst_n = 1'b1;
        tick();
        check_val("idle_in_ready", in_ready_a, 1'b1);
        check_val("idle_acc", out_acc_a, 24'h0);
        check_val("idle_count", out_count_a, 8'd0);

        // Single pair 64 * 0.5 = 32
        send_pair(8'd64, 8'd64, 1'b1, 16'd32, rc);
        check_val("single_run", rc, 32'd17);
        check_val("single_acc", out_acc_a, 24'd32);
        check_val("single_count", out_count_a, 8'd1);
        check_val("single_sat", out_sat_a, 1'b0);
        check_val("single_err", out_err_a, 1'b0);
        drain();

        // Three pairs 100 - 40 + 25 = 85
        send_pair(8'd3, 8'd5, 1'b0, 16'd100, rc);
        send_pair(8'hF0, 8'd7, 1'b0, 16'hFFD8, rc);
        send_pair(8'd9, 8'h81, 1'b1, 16'd25, rc);
        check_val("three_acc24", out_acc_a, 24'd85);
        check_val("three_acc16", out_acc_b, 16'd85);
        check_val("three_count", out_count_a, 8'd3);
        drain();

        // Backpressure: result frozen, held in_valid ignored
        send_pair(8'd1, 8'd1, 1'b1, 16'd7, rc);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("bp_ready", in_ready_a, 1'b0);
            check_val("bp_start", mul_start_a, 1'b0);
            check_val("bp_acc", out_acc_a, 24'd7);
            check_val("bp_count", out_count_a, 8'd1);
        end
        in_valid = 1'b0;
        drain();
        send_pair(8'd2, 8'd2, 1'b1, 16'd5, rc);
        check_val("bp_next_acc", out_acc_a, 24'd5);
        check_val("bp_next_count", out_count_a, 8'd1);
        drain();

        // Positive saturation, continued accumulation from the clamp
        send_pair(8'd1, 8'd1, 1'b0, 16'h7000, rc);
        send_pair(8'd1, 8'd1, 1'b0, 16'h7000, rc);
        check_val("satp_acc16", out_acc_b, 16'h7FFF);
        check_val("satp_acc24", out_acc_a, 24'h00E000);
        send_pair(8'd1, 8'd1, 1'b1, 16'hF000, rc);
        check_val("satc_acc16", out_acc_b, 16'h6FFF);
        check_val("satc_sat16", out_sat_b, 1'b1);
        check_val("satc_acc24", out_acc_a, 24'h00D000);
        check_val("satc_sat24", out_sat_a, 1'b0);
        drain();
        send_pair(8'd1, 8'd1, 1'b1, 16'd1, rc);
        check_val("sat_clr_acc16", out_acc_b, 16'd1);
        check_val("sat_clr_sat16", out_sat_b, 1'b0);
        drain();

        // Negative saturation
        send_pair(8'h80, 8'h80, 1'b0, 16'h8000, rc);
        send_pair(8'h80, 8'h80, 1'b1, 16'h8000, rc);
        check_val("satn_acc16", out_acc_b, 16'h8000);
        check_val("satn_sat16", out_sat_b, 1'b1);
        check_val("satn_acc24", out_acc_a, 24'hFF0000);
        check_val("satn_sat24", out_sat_a, 1'b0);
        drain();

        // Timeout: done never arrives
        hang = 1'b1;
        send_pair(8'd4, 8'd4, 1'b1, 16'd99, rc);
        check_val("tmo_run", rc, 32'd32);
        check_val("tmo_err", out_err_a, 1'b1);
        check_val("tmo_acc", out_acc_a, 24'd0);
        check_val("tmo_count", out_count_a, 8'd1);
        drain();
        hang = 1'b0;

        // Reset in the middle of RUN with a partial sum pending
        send_pair(8'd1, 8'd1, 1'b0, 16'd50, rc);
        stub_y   = 16'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check_val("mid_start", mul_start_a, 1'b1);
        check_val("mid_acc", out_acc_a, 24'd50);
        rst_n = 1'b0;
        #1;
        check_val("mrst_start", mul_start_a, 1'b0);
        check_val("mrst_valid", out_valid_a, 1'b0);
        check_val("mrst_acc", out_acc_a, 24'd0);
        check_val("mrst_ready", in_ready_a, 1'b0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        check_val("after_rst_ready", in_ready_a, 1'b1);
        check_val("after_rst_count", out_count_a, 8'd0);
        send_pair(8'd1, 8'd1, 1'b1, 16'd3, rc);
        check_val("after_rst_acc", out_acc_a, 24'd3);
        check_val("after_rst_cnt1", out_count_a, 8'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
